pair_feeder: RTL and testbench
==============================

PAIR_FEEDER -- requirements
Module: pair_feeder

Interface
REQ-001 Parameter DATA_W, default 8: width of each operand.
REQ-002 Parameter DEPTH, default 4: number of operand pairs buffered; power of two, ≥2.
REQ-003 clk  input  1: single clock; every state update occurs on its rising edge.
REQ-004 reset  input  1: synchronous, active-high reset, sampled on the rising edge of clk.
REQ-005 in_valid  input  1: upstream presents a pair this cycle.
REQ-006 in_a, in_b  input  DATA_W each: operand pair.
REQ-007 in_ready  output  1: feeder accepts a pair this cycle; transfer = in_valid & in_ready.
REQ-008 count  input  4: controller step number (0..9).
REQ-009 start  output  1: one-cycle pulse launching a two-pair controller job.
REQ-010 pair_a, pair_b  output  DATA_W each: head-of-buffer pair driven to the datapath load registers.
REQ-011 level  output  clog2(DEPTH)+1: pairs currently buffered.
REQ-012 busy  output  1: a launched job has not yet consumed both pairs and reached step 9.
REQ-013 err  output  1: sticky protocol-violation flag.

Function
REQ-014 in_ready SHALL equal (level < DEPTH); push and pop in the same cycle is permitted at any level, but no push is accepted when level == DEPTH.
REQ-015 Pairs SHALL be consumed in push order; pair_a/pair_b SHALL show the head entry combinationally from storage, 0 when empty.
REQ-016 States: IDLE, LAUNCH, RUN.
REQ-017 IDLE -> LAUNCH when level ≥ 2; start = 1 only in LAUNCH, for exactly one cycle; LAUNCH -> RUN unconditionally.
REQ-018 Entering RUN arms flags arm0 and arm5.
REQ-019 In RUN: count == 0 with arm0 set -> pop at end of cycle, clear arm0; count == 5 with arm5 set -> pop, clear arm5; at most one pop per cycle.
REQ-020 RUN -> IDLE on the cycle count == 9 with both flags clear; a new start may issue at the earliest two cycles later (IDLE then LAUNCH).
REQ-021 busy = 1 in LAUNCH and RUN.
REQ-022 Pops occur only in RUN; count values other than 0/5 (or with flag clear) SHALL not pop.
REQ-023 A pop request with level == 0 SHALL not change storage and SHALL set err; count == 9 in RUN with either flag set SHALL set err and still return to IDLE.
REQ-024 Read/write pointers wrap modulo DEPTH; level is updated as +1 push, −1 pop, unchanged on both or neither.
REQ-025 Latency: pair pushed into empty buffer visible on pair_a/pair_b the following cycle.

Reset
REQ-026 On reset: state IDLE, pointers 0, level 0, arm0/arm5 0, start 0, busy 0, err 0, in_ready 1, pair_a/pair_b 0.
REQ-027 Reset mid-job SHALL discard all buffered pairs and abort the job with no further start or pop; reset dominates a simultaneous push.

Structure
REQ-028 Shared package pipe_pkg SHALL hold DATA_W default and step constants STEP_LOAD_N = 4'd0, STEP_LOAD_N1 = 4'd5, STEP_LAST = 4'd9; pair_feeder and the controller both use them.
REQ-029 Storage, pointers and level SHALL be a sub-module pair_fifo (push, pop, full, empty, level); job FSM and flags stay in pair_feeder.

Verification
REQ-030 Push (3,4),(−5 as 8'hFB,2) into empty buffer -> start pulses once on cycle 3 after first push; pair_a/pair_b = 3/4 at count 0, FB/2 at count 5; level 2->1->0.
REQ-031 Push 5 pairs back-to-back with no job -> in_ready drops after 4th, 5th held until a pop; level never exceeds 4.
REQ-032 Full buffer, push offered on pop cycle (count 0) -> push rejected that cycle, accepted next; order preserved across pointer wrap.
REQ-033 Count held at 0 for 3 cycles in RUN -> exactly one pop; count 9 before 5 -> err = 1, state IDLE.
REQ-034 Reset asserted at count 5 mid-job -> next cycle level 0, busy 0, start 0, err 0, in_ready 1.
REQ-035 Four pairs buffered -> two consecutive jobs, each consuming two pairs in order, second start only after first job's count 9.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared constants for the operand-pair feeder and the step controller it serves.
// Holds the default operand width, the controller step numbers and the job-FSM state encoding.
package pipe_pkg;

    localparam int DATA_W_DEFAULT = 8;

    localparam logic [3:0] STEP_LOAD_N  = 4'd0;
    localparam logic [3:0] STEP_LOAD_N1 = 4'd5;
    localparam logic [3:0] STEP_LAST    = 4'd9;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_RUN    = 2'd2
    } feeder_state_e;

endpackage

// File: rtl/pair_feeder_if.sv
// Bundle of upstream handshake, controller step input and datapath-facing outputs of pair_feeder.
// The master side drives pairs and the step count; the slave side is the feeder.
interface pair_feeder_if
    import pipe_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT,
    parameter int DEPTH  = 4
);
    localparam int LEVEL_W = $clog2(DEPTH) + 1;

    logic               in_valid;
    logic [DATA_W-1:0]  in_a;
    logic [DATA_W-1:0]  in_b;
    logic               in_ready;
    logic [3:0]         count;
    logic               start;
    logic [DATA_W-1:0]  pair_a;
    logic [DATA_W-1:0]  pair_b;
    logic [LEVEL_W-1:0] level;
    logic               busy;
    logic               err;

    modport master (
        output in_valid, in_a, in_b, count,
        input  in_ready, start, pair_a, pair_b, level, busy, err
    );

    modport slave (
        input  in_valid, in_a, in_b, count,
        output in_ready, start, pair_a, pair_b, level, busy, err
    );

endinterface

// File: rtl/pair_fifo.sv
// Circular buffer of operand pairs; pushes are ignored when full and pops when empty.
// The head pair is presented combinationally and reads as zero while the buffer is empty.
module pair_fifo #(
    parameter  int DATA_W  = 8,
    parameter  int DEPTH   = 4,
    localparam int PTR_W   = $clog2(DEPTH),
    localparam int LEVEL_W = PTR_W + 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               push,
    input  logic               pop,
    input  logic [DATA_W-1:0]  wr_a,
    input  logic [DATA_W-1:0]  wr_b,
    output logic [DATA_W-1:0]  rd_a,
    output logic [DATA_W-1:0]  rd_b,
    output logic               full,
    output logic               empty,
    output logic [LEVEL_W-1:0] level
);

    logic [2*DATA_W-1:0] mem_q [DEPTH];
    logic [2*DATA_W-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LEVEL_W-1:0]  level_q, level_d;
    logic                do_push_s, do_pop_s;

    assign full  = (level_q == LEVEL_W'(DEPTH));
    assign empty = (level_q == {LEVEL_W{1'b0}});
    assign level = level_q;

    // Next-state of storage, pointers and occupancy; pointers wrap naturally as DEPTH is a power of two.
    always_comb begin
        do_push_s = push && !full;
        do_pop_s  = pop && !empty;
        mem_d     = mem_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        level_d   = level_q;
        if (do_push_s) begin
            mem_d[wr_ptr_q] = {wr_a, wr_b};
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (do_pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({do_push_s, do_pop_s})
            2'b10:   level_d = level_q + LEVEL_W'(1);
            2'b01:   level_d = level_q - LEVEL_W'(1);
            default: level_d = level_q;
        endcase
    end

    // Head-of-buffer read, forced to zero when nothing is stored.
    always_comb begin
        if (empty) begin
            {rd_a, rd_b} = {(2*DATA_W){1'b0}};
        end else begin
            {rd_a, rd_b} = mem_q[rd_ptr_q];
        end
    end

    // Storage and pointer registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {(2*DATA_W){1'b0}};
            end
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            level_q  <= {LEVEL_W{1'b0}};
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

endmodule

// File: rtl/pair_feeder.sv
// Buffers operand pairs and launches two-pair controller jobs, popping one pair at step 0
// and one at step 5 of each job; protocol slips raise a sticky error flag.
module pair_feeder
    import pipe_pkg::*;
#(
    parameter  int DATA_W  = DATA_W_DEFAULT,
    parameter  int DEPTH   = 4,
    localparam int LEVEL_W = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          reset,
    pair_feeder_if.slave  bus
);

    feeder_state_e      state_q, state_d;
    logic               arm0_q, arm0_d;
    logic               arm5_q, arm5_d;
    logic               err_q, err_d;
    logic               pop_req_s;
    logic               full_s, empty_s;
    logic [LEVEL_W-1:0] level_s;
    logic [DATA_W-1:0]  head_a_s, head_b_s;

    pair_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (bus.in_valid),
        .pop   (pop_req_s),
        .wr_a  (bus.in_a),
        .wr_b  (bus.in_b),
        .rd_a  (head_a_s),
        .rd_b  (head_b_s),
        .full  (full_s),
        .empty (empty_s),
        .level (level_s)
    );

    assign bus.in_ready = !full_s;
    assign bus.pair_a   = head_a_s;
    assign bus.pair_b   = head_b_s;
    assign bus.level    = level_s;
    assign bus.start    = (state_q == ST_LAUNCH);
    assign bus.busy     = (state_q != ST_IDLE);
    assign bus.err      = err_q;

    // Job sequencing: launch once two pairs are buffered, then consume them at the load steps.
    always_comb begin
        state_d   = state_q;
        arm0_d    = arm0_q;
        arm5_d    = arm5_q;
        err_d     = err_q;
        pop_req_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (level_s >= LEVEL_W'(2)) begin
                    state_d = ST_LAUNCH;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LAUNCH: begin
                state_d = ST_RUN;
                arm0_d  = 1'b1;
                arm5_d  = 1'b1;
            end
            ST_RUN: begin
                if ((bus.count == STEP_LOAD_N) && arm0_q) begin
                    pop_req_s = 1'b1;
                    arm0_d    = 1'b0;
                end else if ((bus.count == STEP_LOAD_N1) && arm5_q) begin
                    pop_req_s = 1'b1;
                    arm5_d    = 1'b0;
                end else if (bus.count == STEP_LAST) begin
                    // Finishing with a load still pending is a protocol slip, but the job ends regardless.
                    state_d = ST_IDLE;
                    arm0_d  = 1'b0;
                    arm5_d  = 1'b0;
                    err_d   = err_q | arm0_q | arm5_q;
                end else begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_IDLE;
                arm0_d  = 1'b0;
                arm5_d  = 1'b0;
            end
        endcase
        if (pop_req_s && empty_s) begin
            err_d = 1'b1;
        end else begin
            err_d = err_d;
        end
    end

    // FSM state, load flags and sticky error.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            arm0_q  <= 1'b0;
            arm5_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            arm0_q  <= arm0_d;
            arm5_q  <= arm5_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_pair_feeder.sv
// Directed bench for pair_feeder: launch timing, full/wrap behaviour, error cases, reset abort, back-to-back jobs.
module tb_pair_feeder;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;
    int   start_cnt;
    int   start_base;

    pair_feeder_if #(.DATA_W(8), .DEPTH(4)) bus ();

    pair_feeder #(.DATA_W(8), .DEPTH(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.start === 1'b1) start_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic push_pair(input logic [7:0] a, input logic [7:0] b);
        bus.in_valid = 1'b1;
        bus.in_a     = a;
        bus.in_b     = b;
        tick();
        bus.in_valid = 1'b0;
    endtask

    initial begin
        n_checks     = 0;
        n_errors     = 0;
        start_cnt    = 0;
        reset        = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_a     = 8'h00;
        bus.in_b     = 8'h00;
        bus.count    = 4'd7;
        tick();
        tick();
        check_eq("rst_level", 32'(bus.level), 32'd0);
        check_eq("rst_ready", 32'(bus.in_ready), 32'd1);
        check_eq("rst_start", 32'(bus.start), 32'd0);
        check_eq("rst_busy", 32'(bus.busy), 32'd0);
        check_eq("rst_err", 32'(bus.err), 32'd0);
        check_eq("rst_pair_a", 32'(bus.pair_a), 32'd0);
        reset = 1'b0;

        // Basic job: (3,4) then (FB,2)
        start_base = start_cnt;
        push_pair(8'h03, 8'h04);
        check_eq("a_lvl1", 32'(bus.level), 32'd1);
        check_eq("a_head_a", 32'(bus.pair_a), 32'h03);
        check_eq("a_head_b", 32'(bus.pair_b), 32'h04);
        push_pair(8'hFB, 8'h02);
        check_eq("a_lvl2", 32'(bus.level), 32'd2);
        check_eq("a_nostart", 32'(bus.start), 32'd0);
        tick();
        check_eq("a_start", 32'(bus.start), 32'd1);
        check_eq("a_busy", 32'(bus.busy), 32'd1);
        bus.count = 4'd0;
        tick();
        check_eq("a_start_off", 32'(bus.start), 32'd0);
        check_eq("a_run_lvl", 32'(bus.level), 32'd2);
        check_eq("a_c0_a", 32'(bus.pair_a), 32'h03);
        check_eq("a_c0_b", 32'(bus.pair_b), 32'h04);
        tick();
        check_eq("a_pop1_lvl", 32'(bus.level), 32'd1);
        bus.count = 4'd5;
        check_eq("a_c5_a", 32'(bus.pair_a), 32'hFB);
        check_eq("a_c5_b", 32'(bus.pair_b), 32'h02);
        tick();
        check_eq("a_pop2_lvl", 32'(bus.level), 32'd0);
        check_eq("a_empty_a", 32'(bus.pair_a), 32'd0);
        bus.count = 4'd9;
        tick();
        check_eq("a_idle_busy", 32'(bus.busy), 32'd0);
        check_eq("a_err", 32'(bus.err), 32'd0);
        check_eq("a_starts", 32'(start_cnt - start_base), 32'd1);
        bus.count = 4'd7;

        // Fill to full, fifth pair held, push on pop cycle rejected, wrap order
        for (int i = 0; i < 4; i++) begin
            push_pair(8'(i + 1), 8'(8'h10 + i));
            check_eq("b_fill_lvl", 32'(bus.level), 32'(i + 1));
        end
        check_eq("b_full_ready", 32'(bus.in_ready), 32'd0);
        bus.in_valid = 1'b1;
        bus.in_a     = 8'h05;
        bus.in_b     = 8'h14;
        tick();
        tick();
        check_eq("b_held_lvl", 32'(bus.level), 32'd4);
        check_eq("b_held_ready", 32'(bus.in_ready), 32'd0);
        check_eq("b_head1", 32'(bus.pair_a), 32'h01);
        bus.count = 4'd0;
        tick();
        check_eq("b_popcyc_lvl", 32'(bus.level), 32'd3);
        check_eq("b_popcyc_ready", 32'(bus.in_ready), 32'd1);
        tick();
        check_eq("b_accept_lvl", 32'(bus.level), 32'd4);
        bus.in_valid = 1'b0;
        bus.count    = 4'd5;
        check_eq("b_head2", 32'(bus.pair_a), 32'h02);
        tick();
        check_eq("b_head3", 32'(bus.pair_a), 32'h03);
        bus.count = 4'd9;
        tick();
        check_eq("b_idle", 32'(bus.busy), 32'd0);
        bus.count = 4'd7;
        tick();
        check_eq("b_start2", 32'(bus.start), 32'd1);
        tick();
        bus.count = 4'd0;
        tick();
        check_eq("b_head4_a", 32'(bus.pair_a), 32'h04);
        check_eq("b_head4_b", 32'(bus.pair_b), 32'h13);
        bus.count = 4'd5;
        tick();
        check_eq("b_wrap_a", 32'(bus.pair_a), 32'h05);
        check_eq("b_wrap_b", 32'(bus.pair_b), 32'h14);
        check_eq("b_wrap_lvl", 32'(bus.level), 32'd1);
        bus.count = 4'd9;
        tick();
        bus.count = 4'd7;
        tick();
        check_eq("b_lvl1_nostart", 32'(bus.start), 32'd0);

        // Count held at 0 gives one pop; ending at 9 before 5 flags err
        push_pair(8'h06, 8'h15);
        tick();
        check_eq("c_start", 32'(bus.start), 32'd1);
        tick();
        bus.count = 4'd0;
        tick();
        tick();
        tick();
        check_eq("c_one_pop_lvl", 32'(bus.level), 32'd1);
        check_eq("c_head", 32'(bus.pair_a), 32'h06);
        bus.count = 4'd9;
        tick();
        check_eq("c_err", 32'(bus.err), 32'd1);
        check_eq("c_idle", 32'(bus.busy), 32'd0);
        bus.count = 4'd7;
        tick();
        check_eq("c_err_sticky", 32'(bus.err), 32'd1);

        // Reset mid-job at count 5, with a simultaneous push
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_eq("d_clr_err", 32'(bus.err), 32'd0);
        push_pair(8'h21, 8'h31);
        push_pair(8'h22, 8'h32);
        tick();
        tick();
        bus.count = 4'd0;
        tick();
        check_eq("d_pre_lvl", 32'(bus.level), 32'd1);
        bus.count    = 4'd5;
        reset        = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_a     = 8'h77;
        bus.in_b     = 8'h78;
        start_base   = start_cnt;
        tick();
        reset        = 1'b0;
        bus.in_valid = 1'b0;
        bus.count    = 4'd7;
        check_eq("d_lvl", 32'(bus.level), 32'd0);
        check_eq("d_busy", 32'(bus.busy), 32'd0);
        check_eq("d_start", 32'(bus.start), 32'd0);
        check_eq("d_err", 32'(bus.err), 32'd0);
        check_eq("d_ready", 32'(bus.in_ready), 32'd1);
        check_eq("d_pair_a", 32'(bus.pair_a), 32'd0);
        tick();
        tick();
        check_eq("d_no_restart", 32'(start_cnt - start_base), 32'd0);

        // Four pairs, two consecutive jobs
        start_base = start_cnt;
        push_pair(8'h41, 8'h51);
        push_pair(8'h42, 8'h52);
        push_pair(8'h43, 8'h53);
        check_eq("e_start1", 32'(bus.start), 32'd1);
        push_pair(8'h44, 8'h54);
        check_eq("e_lvl4", 32'(bus.level), 32'd4);
        check_eq("e_head1", 32'(bus.pair_a), 32'h41);
        bus.count = 4'd0;
        tick();
        check_eq("e_head2", 32'(bus.pair_a), 32'h42);
        bus.count = 4'd5;
        tick();
        check_eq("e_head3_a", 32'(bus.pair_a), 32'h43);
        check_eq("e_head3_b", 32'(bus.pair_b), 32'h53);
        check_eq("e_one_start", 32'(start_cnt - start_base), 32'd1);
        bus.count = 4'd9;
        tick();
        check_eq("e_gap_start", 32'(bus.start), 32'd0);
        bus.count = 4'd7;
        tick();
        check_eq("e_start2", 32'(bus.start), 32'd1);
        tick();
        bus.count = 4'd0;
        tick();
        check_eq("e_head4", 32'(bus.pair_a), 32'h44);
        bus.count = 4'd5;
        tick();
        check_eq("e_drain_lvl", 32'(bus.level), 32'd0);
        bus.count = 4'd9;
        tick();
        bus.count = 4'd7;
        check_eq("e_end_busy", 32'(bus.busy), 32'd0);
        check_eq("e_end_err", 32'(bus.err), 32'd0);
        check_eq("e_starts", 32'(start_cnt - start_base), 32'd2);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
